// File: rtl/riscv_pkg.sv
// Shared RV32/RV64 constants for the memory and write-back stages.
// Load funct3 encodings and the default datapath width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_pipe_load_align.sv
// Combinational RV load extraction: picks the addressed byte/half from the
// raw memory word and sign- or zero-extends it to XLEN.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] read_data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign word     = read_data[31:0];
  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  // Halves are assumed aligned; the low offset bit is deliberately ignored.
  assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data = XLEN'(signed'(word));
    case (funct3)
      F3_LB:   data = XLEN'(signed'(byte_sel));
      F3_LH:   data = XLEN'(signed'(half_sel));
      F3_LBU:  data = XLEN'(byte_sel);
      F3_LHU:  data = XLEN'(half_sel);
      default: data = XLEN'(signed'(word));
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// Parametrised MEM/WB pipeline register: DEPTH stages with valid, stall and
// flush, load alignment at capture, and a pre-muxed write-back port.
module mem_wb_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int RADDR_W    = 5,
  parameter int DEPTH      = 1,
  parameter int LOAD_ALIGN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]    in_result,
  input  logic [XLEN-1:0]    in_read_data,
  input  logic               in_memtoreg,
  input  logic               in_regwrite,
  input  logic [2:0]         in_funct3,
  input  logic [1:0]         in_addr_lo,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [RADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]    out_result,
  output logic [XLEN-1:0]    out_read_data,
  output logic               out_memtoreg,
  output logic               out_regwrite,
  output logic [XLEN-1:0]    wb_data,
  output logic               wb_we
);

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    result;
    logic [XLEN-1:0]    read_data;
    logic               memtoreg;
    logic               regwrite;
  } stage_t;

  stage_t          stage_q [DEPTH];
  stage_t          entry_d;
  logic [XLEN-1:0] load_data;

  generate
    if (LOAD_ALIGN != 0) begin : g_align
      logic [XLEN-1:0] aligned;

      load_align #(.XLEN(XLEN)) u_load_align (
        .read_data (in_read_data),
        .funct3    (in_funct3),
        .addr_lo   (in_addr_lo),
        .data      (aligned)
      );

      // Non-load instructions keep the raw word so forwarding sees it untouched.
      assign load_data = in_memtoreg ? aligned : in_read_data;
    end else begin : g_raw
      assign load_data = in_read_data;
    end
  endgenerate

  always_comb begin
    entry_d           = '0;
    entry_d.valid     = in_valid;
    entry_d.rd        = in_rd;
    entry_d.result    = in_result;
    entry_d.read_data = load_data;
    entry_d.memtoreg  = in_memtoreg;
    entry_d.regwrite  = in_regwrite & in_valid;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    stage_t d;
    stage_t q;

    if (k == 0) begin : g_first
      assign d = entry_d;
    end else begin : g_next
      assign d = stage_q[k-1];
    end

    // Flush only kills the control bits; payload is left as-is.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (flush) begin
        q.valid    <= 1'b0;
        q.regwrite <= 1'b0;
      end else if (!stall) begin
        q <= d;
      end
    end

    assign stage_q[k] = q;
  end

  assign out_valid     = stage_q[DEPTH-1].valid;
  assign out_rd        = stage_q[DEPTH-1].rd;
  assign out_result    = stage_q[DEPTH-1].result;
  assign out_read_data = stage_q[DEPTH-1].read_data;
  assign out_memtoreg  = stage_q[DEPTH-1].memtoreg;
  assign out_regwrite  = stage_q[DEPTH-1].regwrite;

  assign wb_data = out_memtoreg ? out_read_data : out_result;
  assign wb_we   = out_valid & out_regwrite & (out_rd != '0);

endmodule
